// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and stall/flush controller for a 5-stage pipeline. It resolves three
//   kinds of events in a fixed priority order:
//     1. data-memory wait (dmem_busy)   -> freeze the whole pipe
//     2. control redirect (ex_redirect) -> flush IF/ID, bubble ID/EX
//     3. load-use data hazard           -> hold PC and IF/ID, bubble ID/EX
//   A redirect that shows up while the pipe is frozen is remembered and is
//   applied on the first cycle after the memory wait ends.
//   The control outputs are combinational from the state and the current
//   inputs. Two saturating counters track stalled and flushed cycles.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   id_rs_addr/rt_addr    source registers of the instruction in ID
//   id_uses_rt            ID instruction reads rt as a source
//   ex_MemRead/rt_addr    load flag and load destination in EX
//   ex_redirect           branch taken or jump resolved in EX
//   dmem_busy             MEM-stage access has not completed
//   pc_write, if_id_write enables for the PC and IF/ID
//   if_id_flush           IF/ID loads a NOP
//   id_ex_stall           ID/EX holds its contents
//   id_ex_bubble          ID/EX loads all-zero control
//   ex_mem_stall          hold EX/MEM and MEM/WB
//   stall_cycles          saturating count of cycles with pc_write=0
//   flush_count           saturating count of cycles with if_id_flush=1
//   state_o               FSM state (RUN=00, WAIT=01, REDIR=10)
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal flow; redirect and load-use evaluated live
// WAIT  | a memory wait was seen last cycle, no redirect pending
// REDIR | a memory wait is in progress (or just ended) with a pending redirect
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rt,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rt_addr,
  input  logic             ex_redirect,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             ex_mem_stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_REDIR = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             load_use;

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign load_use = ex_MemRead && (ex_rt_addr != 5'd0) &&
                    ((ex_rt_addr == id_rs_addr) ||
                     (id_uses_rt && (ex_rt_addr == id_rt_addr)));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_stall = 1'b0;
    state_d      = state_q;

    if (dmem_busy) begin
      // Freeze everything; the pending redirect can only be set here, never cleared.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      if (ex_redirect || (state_q == ST_REDIR)) state_d = ST_REDIR;
      else                                      state_d = ST_WAIT;
    end else if (ex_redirect || (state_q == ST_REDIR)) begin
      // Live or pending redirect: the load-use condition belongs to a
      // wrong-path instruction and is dropped.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = ST_RUN;
    end else begin
      // The load leaves EX next cycle, so this yields exactly one bubble.
      if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      if (!pc_write && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
      if (if_id_flush && (flush_q != {CNT_W{1'b1}}))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs_addr, id_rt_addr, ex_rt_addr;
  logic        id_uses_rt, ex_MemRead, ex_redirect, dmem_busy;

  logic        pc_write, if_id_write, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall;
  logic [15:0] stall_cycles, flush_count;
  logic [1:0]  state_o;

  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_stall, s_id_ex_bubble, s_ex_mem_stall;
  logic [3:0]  s_stall_cycles, s_flush_count;
  logic [1:0]  s_state_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt_addr(ex_rt_addr),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .state_o(state_o)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt_addr(ex_rt_addr),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_stall(s_id_ex_stall), .id_ex_bubble(s_id_ex_bubble), .ex_mem_stall(s_ex_mem_stall),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count), .state_o(s_state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // pc_write, if_id_write, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_write, if_id_write, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall},
        {26'd0, exp});
    assert (!(id_ex_stall && id_ex_bubble) && !(if_id_flush && !if_id_write))
    else begin
      failures++;
      $error("FAIL %s_exclusive stall=%0b bubble=%0b flush=%0b if_id_write=%0b",
             tag, id_ex_stall, id_ex_bubble, if_id_flush, if_id_write);
    end
  endtask

  task automatic idle();
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rt = 1'b0;
    ex_MemRead = 1'b0; ex_rt_addr = 5'd0; ex_redirect = 1'b0; dmem_busy = 1'b0;
  endtask

  // Advance one cycle; leave the bench 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  localparam logic [5:0] CTL_IDLE   = 6'b110000;
  localparam logic [5:0] CTL_LOADU  = 6'b000010;
  localparam logic [5:0] CTL_FLUSH  = 6'b111010;
  localparam logic [5:0] CTL_FREEZE = 6'b000101;

  initial begin
    idle();
    reset = 1'b0;
    #2;
    chk_ctl("reset_ctl", CTL_IDLE);
    chk("reset_state", state_o, 2'b00);
    chk("reset_stall_cnt", stall_cycles, 0);
    chk("reset_flush_cnt", flush_count, 0);
    tick();
    reset = 1'b1;
    #1;
    chk_ctl("post_reset_ctl", CTL_IDLE);

    // Load-use on rs
    ex_MemRead = 1'b1; ex_rt_addr = 5'd8; id_rs_addr = 5'd8;
    #1 chk_ctl("loaduse_rs_ctl", CTL_LOADU);
    tick();
    chk("loaduse_rs_stall_cnt", stall_cycles, 1);
    idle();
    #1 chk_ctl("loaduse_cleared_ctl", CTL_IDLE);

    // Load into r0 is never a hazard
    ex_MemRead = 1'b1; ex_rt_addr = 5'd0; id_rs_addr = 5'd0;
    #1 chk_ctl("loaduse_r0_ctl", CTL_IDLE);
    tick();
    chk("loaduse_r0_stall_cnt", stall_cycles, 1);

    // rt match only counts when ID actually reads rt
    idle();
    ex_MemRead = 1'b1; ex_rt_addr = 5'd9; id_rt_addr = 5'd9; id_rs_addr = 5'd3;
    #1 chk_ctl("rt_unused_ctl", CTL_IDLE);
    tick();
    id_uses_rt = 1'b1;
    #1 chk_ctl("rt_used_ctl", CTL_LOADU);
    tick();
    chk("rt_used_stall_cnt", stall_cycles, 2);
    idle();

    // Redirect wins over concurrent load-use
    ex_redirect = 1'b1; ex_MemRead = 1'b1; ex_rt_addr = 5'd8; id_rs_addr = 5'd8;
    #1 chk_ctl("redirect_ctl", CTL_FLUSH);
    tick();
    chk("redirect_flush_cnt", flush_count, 1);
    chk("redirect_stall_cnt", stall_cycles, 2);
    chk("redirect_state", state_o, 2'b00);
    idle();

    // Redirect during memory wait
    do_reset();
    dmem_busy = 1'b1;
    #1 chk_ctl("memwait_c1_ctl", CTL_FREEZE);
    tick();
    chk("memwait_c1_state", state_o, 2'b01);
    ex_redirect = 1'b1;
    #1 chk_ctl("memwait_c2_ctl", CTL_FREEZE);
    tick();
    chk("memwait_c2_state", state_o, 2'b10);
    ex_redirect = 1'b0; ex_MemRead = 1'b1; ex_rt_addr = 5'd4; id_rs_addr = 5'd4;
    #1 chk_ctl("memwait_c3_ctl", CTL_FREEZE);
    tick();
    chk("memwait_c3_state", state_o, 2'b10);
    dmem_busy = 1'b0;
    #1 chk_ctl("memwait_c4_ctl", CTL_FLUSH);
    tick();
    chk("memwait_c4_state", state_o, 2'b00);
    chk("memwait_stall_cnt", stall_cycles, 3);
    chk("memwait_flush_cnt", flush_count, 1);
    idle();
    #1 chk_ctl("memwait_c5_ctl", CTL_IDLE);

    // WAIT followed by load-use with memory done: normal evaluation
    do_reset();
    dmem_busy = 1'b1;
    tick();
    chk("wait_state", state_o, 2'b01);
    dmem_busy = 1'b0; ex_MemRead = 1'b1; ex_rt_addr = 5'd7; id_rs_addr = 5'd7;
    #1 chk_ctl("wait_loaduse_ctl", CTL_LOADU);
    tick();
    chk("wait_exit_state", state_o, 2'b00);
    chk("wait_stall_cnt", stall_cycles, 2);
    idle();

    // Reset while a redirect is pending
    do_reset();
    dmem_busy = 1'b1;
    tick();
    ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    chk("rst_redir_pre_state", state_o, 2'b10);
    reset = 1'b0;
    #1;
    chk("rst_redir_async_state", state_o, 2'b00);
    chk("rst_redir_async_stall", stall_cycles, 0);
    chk("rst_redir_async_flush", flush_count, 0);
    idle();
    tick();
    reset = 1'b1;
    #1 chk_ctl("rst_redir_release_ctl", CTL_IDLE);
    tick();
    chk_ctl("rst_redir_next_ctl", CTL_IDLE);
    chk("rst_redir_flush_cnt", flush_count, 0);
    chk("rst_redir_state", state_o, 2'b00);

    // Saturation of the narrow counter
    do_reset();
    dmem_busy = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt4", s_stall_cycles, 15);
    chk("sat_cnt16", stall_cycles, 20);
    dmem_busy = 1'b0;
    tick();
    chk("sat_exit_state", state_o, 2'b00);
    chk("sat_cnt4_hold", s_stall_cycles, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
